// File: rtl/rf_pkg.sv
// rf_pkg: register-file sizes and per-port types shared by decode, write-back and the GPR file
`ifndef XLEN
`define XLEN 32
`endif
`ifndef GPRS_COUNT
`define GPRS_COUNT 32
`endif
package rf_pkg;
    localparam int XLEN = `XLEN;
    localparam int GPRS_COUNT = `GPRS_COUNT;
    localparam int AW = $clog2(GPRS_COUNT);
    localparam int RD_PORTS = 2;
    localparam int WR_PORTS = 1;
    typedef logic [AW-1:0] addr_t;
    typedef logic [XLEN-1:0] data_t;
    typedef addr_t [RD_PORTS-1:0] rd_addr_arr_t;
    typedef data_t [RD_PORTS-1:0] rd_data_arr_t;
    typedef addr_t [WR_PORTS-1:0] wr_addr_arr_t;
    typedef data_t [WR_PORTS-1:0] wr_data_arr_t;
endpackage

// File: rtl/constants.sv
// constants: global core sizing macros shared by every block of the core
`ifndef XLEN
`define XLEN 32
`endif
`ifndef GPRS_COUNT
`define GPRS_COUNT 32
`endif

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits; claims set, write-backs clear, flush/reset wipe
module rf_scoreboard import rf_pkg::*; #(
    parameter int GPRS = GPRS_COUNT,
    parameter int WRITE_PORTS = 1,
    localparam int AW = $clog2(GPRS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WRITE_PORTS-1:0]    we,
    input  logic [WRITE_PORTS*AW-1:0] wr_addr,
    input  logic                      issue_valid,
    input  logic [AW-1:0]             issue_addr,
    input  logic                      flush,
    output logic                      issue_ready,
    output logic [GPRS-1:0]           busy
);
    logic [GPRS-1:0] clr;
    logic [GPRS-1:0] set;
    always_comb begin
        clr = '0;
        for (int k = 0; k < WRITE_PORTS; k++)
            if (we[k]) clr[wr_addr[k*AW +: AW]] = 1'b1;
        issue_ready = !flush && (issue_addr == '0 || !busy[issue_addr] || clr[issue_addr]);
        set = '0;
        if (issue_valid && issue_ready && issue_addr != '0) set[issue_addr] = 1'b1;
    end
    // set is applied after clear so a same-cycle re-claim keeps the register busy
    always_ff @(posedge clk)
        if (rst || flush) busy <= '0;
        else busy <= (busy & ~clr) | set;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port GPR file with optional write-to-read bypass and busy scoreboard
module reg_file_sb import rf_pkg::*; #(
    parameter int N = XLEN,
    parameter int GPRS = GPRS_COUNT,
    parameter int READ_PORTS = 2,
    parameter int WRITE_PORTS = 1,
    parameter int BYPASS = 1,
    localparam int AW = $clog2(GPRS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [READ_PORTS*AW-1:0]  rd_addr,
    output logic [READ_PORTS*N-1:0]   rd_data,
    output logic [READ_PORTS-1:0]     rd_busy,
    input  logic [WRITE_PORTS-1:0]    we,
    input  logic [WRITE_PORTS*AW-1:0] wr_addr,
    input  logic [WRITE_PORTS*N-1:0]  wr_data,
    input  logic                      issue_valid,
    input  logic [AW-1:0]             issue_addr,
    output logic                      issue_ready,
    input  logic                      flush
);
    logic [N-1:0] mem [1:GPRS-1];
    logic [GPRS-1:0] busy;
    rf_scoreboard #(.GPRS(GPRS), .WRITE_PORTS(WRITE_PORTS)) u_sb (
        .clk(clk),
        .rst(rst),
        .we(we),
        .wr_addr(wr_addr),
        .issue_valid(issue_valid),
        .issue_addr(issue_addr),
        .flush(flush),
        .issue_ready(issue_ready),
        .busy(busy)
    );
    // later ports overwrite earlier ones, so the highest port wins on collisions
    always_ff @(posedge clk)
        if (rst) for (int r = 1; r < GPRS; r++) mem[r] <= '0;
        else for (int k = 0; k < WRITE_PORTS; k++)
            if (we[k] && wr_addr[k*AW +: AW] != '0) mem[wr_addr[k*AW +: AW]] <= wr_data[k*N +: N];
    for (genvar i = 0; i < READ_PORTS; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic hit;
        logic [N-1:0] fwd;
        assign ra = rd_addr[i*AW +: AW];
        always_comb begin
            hit = 1'b0;
            fwd = '0;
            for (int k = 0; k < WRITE_PORTS; k++)
                if (BYPASS != 0 && we[k] && wr_addr[k*AW +: AW] == ra && ra != '0) begin
                    hit = 1'b1;
                    fwd = wr_data[k*N +: N];
                end
        end
        assign rd_data[i*N +: N] = ra == '0 ? '0 : hit ? fwd : mem[ra];
        assign rd_busy[i] = !hit && busy[ra];
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: table vectors plus random traffic against a behavioural register/busy model
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        rst, issue_valid, flush;
    logic [9:0]  rd_addr, wr_addr;
    logic [63:0] rd_data, rd_data_nb, wr_data;
    logic [1:0]  rd_busy, rd_busy_nb, we;
    logic [4:0]  issue_addr;
    logic        issue_ready, issue_ready_nb;
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] m_reg [32];
    bit   [31:0] m_busy;

    always #5 clk = ~clk;

    reg_file_sb #(.N(32), .GPRS(32), .READ_PORTS(2), .WRITE_PORTS(2), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .issue_valid(issue_valid),
        .issue_addr(issue_addr), .issue_ready(issue_ready), .flush(flush));
    reg_file_sb #(.N(32), .GPRS(32), .READ_PORTS(2), .WRITE_PORTS(2), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .issue_valid(issue_valid),
        .issue_addr(issue_addr), .issue_ready(issue_ready_nb), .flush(flush));

    typedef struct {
        bit rst; bit [1:0] we; bit [4:0] wa0; bit [31:0] wd0; bit [4:0] wa1; bit [31:0] wd1;
        bit [4:0] ra0; bit [4:0] ra1; bit iv; bit [4:0] ia; bit fl;
        bit [31:0] e_d0; bit [31:0] e_nd0; bit e_b0; bit e_rdy;
    } vec_t;
    vec_t tv [21];

    function automatic logic [4:0] wa(int k);
        return wr_addr[k*5 +: 5];
    endfunction

    function automatic bit wr_hits(logic [4:0] a);
        return (we[0] && wa(0) == a) || (we[1] && wa(1) == a);
    endfunction

    function automatic logic [31:0] exp_data(logic [4:0] ra, bit byp);
        if (ra == 0) return 32'h0;
        if (byp && we[1] && wa(1) == ra) return wr_data[63:32];
        if (byp && we[0] && wa(0) == ra) return wr_data[31:0];
        return m_reg[ra];
    endfunction

    function automatic bit exp_busy(logic [4:0] ra, bit byp);
        return ra != 0 && m_busy[ra] && !(byp && wr_hits(ra));
    endfunction

    function automatic bit exp_ready();
        return !flush && (issue_addr == 0 || !m_busy[issue_addr] || wr_hits(issue_addr));
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic model_step();
        bit rdy;
        rdy = exp_ready();
        if (rst) begin
            for (int r = 0; r < 32; r++) m_reg[r] = 32'h0;
            m_busy = '0;
            return;
        end
        for (int k = 0; k < 2; k++)
            if (we[k] && wa(k) != 0) m_reg[wa(k)] = wr_data[k*32 +: 32];
        if (flush) m_busy = '0;
        else begin
            for (int k = 0; k < 2; k++) if (we[k]) m_busy[wa(k)] = 1'b0;
            if (issue_valid && rdy && issue_addr != 0) m_busy[issue_addr] = 1'b1;
        end
    endtask

    task automatic run(vec_t v, bit tbl, int idx);
        logic [4:0] ra;
        rst = v.rst; we = v.we; wr_addr = {v.wa1, v.wa0}; wr_data = {v.wd1, v.wd0};
        rd_addr = {v.ra1, v.ra0}; issue_valid = v.iv; issue_addr = v.ia; flush = v.fl;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            ra = rd_addr[p*5 +: 5];
            chk("rd_data", idx, rd_data[p*32 +: 32], exp_data(ra, 1'b1));
            chk("rd_busy", idx, 32'(rd_busy[p]), 32'(exp_busy(ra, 1'b1)));
            chk("rd_data_nb", idx, rd_data_nb[p*32 +: 32], exp_data(ra, 1'b0));
            chk("rd_busy_nb", idx, 32'(rd_busy_nb[p]), 32'(exp_busy(ra, 1'b0)));
        end
        chk("issue_ready", idx, 32'(issue_ready), 32'(exp_ready()));
        chk("issue_ready_nb", idx, 32'(issue_ready_nb), 32'(exp_ready()));
        if (tbl) begin
            chk("tbl_d0", idx, rd_data[31:0], v.e_d0);
            chk("tbl_nd0", idx, rd_data_nb[31:0], v.e_nd0);
            chk("tbl_b0", idx, 32'(rd_busy[0]), 32'(v.e_b0));
            chk("tbl_rdy", idx, 32'(issue_ready), 32'(v.e_rdy));
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        vec_t v;
        // rst we wa0 wd0 wa1 wd1 ra0 ra1 iv ia fl | e_d0 e_nd0 e_b0 e_rdy
        tv[0]  = '{1'b0, 2'b01, 5'd5, 32'hDEAD, 5'd0, 32'h0,  5'd5, 5'd0,  1'b0, 5'd0,  1'b0, 32'hDEAD, 32'h0,    1'b0, 1'b1};
        tv[1]  = '{1'b1, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  5'd5, 5'd0,  1'b0, 5'd0,  1'b0, 32'hDEAD, 32'hDEAD, 1'b0, 1'b1};
        tv[2]  = '{1'b0, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  5'd5, 5'd0,  1'b0, 5'd0,  1'b0, 32'h0,    32'h0,    1'b0, 1'b1};
        tv[3]  = '{1'b0, 2'b01, 5'd7, 32'h1234, 5'd0, 32'h0,  5'd7, 5'd0,  1'b0, 5'd0,  1'b0, 32'h1234, 32'h0,    1'b0, 1'b1};
        tv[4]  = '{1'b0, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  5'd7, 5'd0,  1'b0, 5'd0,  1'b0, 32'h1234, 32'h1234, 1'b0, 1'b1};
        tv[5]  = '{1'b0, 2'b01, 5'd0, 32'hFFFF, 5'd0, 32'h0,  5'd0, 5'd0,  1'b0, 5'd0,  1'b0, 32'h0,    32'h0,    1'b0, 1'b1};
        tv[6]  = '{1'b0, 2'b11, 5'd3, 32'h11,   5'd3, 32'h22, 5'd3, 5'd0,  1'b0, 5'd0,  1'b0, 32'h22,   32'h0,    1'b0, 1'b1};
        tv[7]  = '{1'b0, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  5'd3, 5'd0,  1'b0, 5'd0,  1'b0, 32'h22,   32'h22,   1'b0, 1'b1};
        tv[8]  = '{1'b0, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  5'd9, 5'd0,  1'b1, 5'd9,  1'b0, 32'h0,    32'h0,    1'b0, 1'b1};
        tv[9]  = '{1'b0, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  5'd9, 5'd0,  1'b1, 5'd9,  1'b0, 32'h0,    32'h0,    1'b1, 1'b0};
        tv[10] = '{1'b0, 2'b01, 5'd9, 32'h99,   5'd0, 32'h0,  5'd9, 5'd0,  1'b1, 5'd9,  1'b0, 32'h99,   32'h0,    1'b0, 1'b1};
        tv[11] = '{1'b0, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  5'd9, 5'd0,  1'b0, 5'd9,  1'b0, 32'h99,   32'h99,   1'b1, 1'b0};
        tv[12] = '{1'b0, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  5'd1, 5'd0,  1'b1, 5'd1,  1'b0, 32'h0,    32'h0,    1'b0, 1'b1};
        tv[13] = '{1'b0, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  5'd1, 5'd0,  1'b1, 5'd2,  1'b0, 32'h0,    32'h0,    1'b1, 1'b1};
        tv[14] = '{1'b0, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  5'd2, 5'd0,  1'b1, 5'd4,  1'b0, 32'h0,    32'h0,    1'b1, 1'b1};
        tv[15] = '{1'b0, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  5'd4, 5'd0,  1'b1, 5'd6,  1'b1, 32'h0,    32'h0,    1'b1, 1'b0};
        tv[16] = '{1'b0, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  5'd4, 5'd9,  1'b0, 5'd6,  1'b0, 32'h0,    32'h0,    1'b0, 1'b1};
        tv[17] = '{1'b0, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  5'd9, 5'd0,  1'b1, 5'd9,  1'b0, 32'h99,   32'h99,   1'b0, 1'b1};
        tv[18] = '{1'b1, 2'b01, 5'd9, 32'h5555, 5'd0, 32'h0,  5'd9, 5'd0,  1'b1, 5'd10, 1'b0, 32'h5555, 32'h99,   1'b0, 1'b1};
        tv[19] = '{1'b0, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  5'd9, 5'd10, 1'b0, 5'd10, 1'b0, 32'h0,    32'h0,    1'b0, 1'b1};
        tv[20] = '{1'b0, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  5'd7, 5'd3,  1'b0, 5'd0,  1'b0, 32'h0,    32'h0,    1'b0, 1'b1};
        rst = 1'b1; we = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        issue_valid = 1'b0; issue_addr = '0; flush = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int r = 0; r < 32; r++) m_reg[r] = 32'h0;
        m_busy = '0;
        for (int i = 0; i < 21; i++) run(tv[i], 1'b1, i);
        for (int i = 0; i < 600; i++) begin
            v = tv[20];
            v.rst = $urandom_range(0, 49) == 0;
            v.we  = 2'($urandom_range(0, 3));
            v.wa0 = 5'($urandom_range(0, 7));
            v.wa1 = 5'($urandom_range(0, 7));
            v.wd0 = $urandom;
            v.wd1 = $urandom;
            v.ra0 = 5'($urandom_range(0, 7));
            v.ra1 = 5'($urandom_range(0, 7));
            v.iv  = $urandom_range(0, 1) == 1;
            v.ia  = 5'($urandom_range(0, 7));
            v.fl  = $urandom_range(0, 15) == 0;
            run(v, 1'b0, 100 + i);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
